// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer: state encoding,
// opcode values, field widths and the decoded-command record.
package fetch_seq_pkg;

   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned OFFSET_W = 16;
   localparam int unsigned IMM_W    = 12;
   localparam int unsigned OPC_W    = 4;

   typedef logic [OPC_W-1:0] opcode_t;

   localparam opcode_t OP_HALT = 4'hC;
   localparam opcode_t OP_BZ   = 4'hD;
   localparam opcode_t OP_JF   = 4'hE;
   localparam opcode_t OP_JB   = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_HALT  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   typedef struct packed {
      logic                inc;
      logic                add;
      logic                sub;
      logic [OFFSET_W-1:0] offset;
      logic                is_halt;
   } dec_t;

   // Branch magnitude is always unsigned; direction lives in add vs sub.
   function automatic logic [OFFSET_W-1:0] zext_imm(input logic [IMM_W-1:0] imm);
      return {{(OFFSET_W-IMM_W){1'b0}}, imm};
   endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Bundle between the fetch sequencer, the pc block, instruction memory and
// the datapath. master = sequencer side, slave = environment side.
interface fetch_seq_if;
   import fetch_seq_pkg::*;

   logic [ADDR_W-1:0]   pc;
   logic                zero;
   logic                stall;
   logic                imem_req;
   logic [ADDR_W-1:0]   imem_addr;
   logic                imem_ack;
   logic [INSTR_W-1:0]  imem_data;
   logic                inc;
   logic                add;
   logic                sub;
   logic [OFFSET_W-1:0] offset;
   logic [INSTR_W-1:0]  instr;
   logic                instr_valid;
   logic                halted;
   logic                err;

   modport master (
      input  pc, zero, stall, imem_ack, imem_data,
      output imem_req, imem_addr, inc, add, sub, offset, instr, instr_valid, halted, err
   );

   modport slave (
      output pc, zero, stall, imem_ack, imem_data,
      input  imem_req, imem_addr, inc, add, sub, offset, instr, instr_valid, halted, err
   );

endinterface

// File: rtl/fetch_seq_decode.sv
// Opcode decode: maps opcode, imm12 and the zero flag to one pc command.
// Purely combinational; the parent gates the result with EXEC && !stall.
module fetch_decode
   import fetch_seq_pkg::*;
(
   input  opcode_t          i_opcode,
   input  logic [IMM_W-1:0] i_imm,
   input  logic             i_zero,
   output dec_t             o_dec
);

   always_comb begin
      o_dec = '0;
      case (i_opcode)
         OP_JF: begin
            o_dec.add    = 1'b1;
            o_dec.offset = zext_imm(i_imm);
         end
         OP_JB: begin
            o_dec.sub    = 1'b1;
            o_dec.offset = zext_imm(i_imm);
         end
         OP_BZ: begin
            if (i_zero) begin
               o_dec.add    = 1'b1;
               o_dec.offset = zext_imm(i_imm);
            end else begin
               o_dec.inc = 1'b1;
            end
         end
         OP_HALT: o_dec.is_halt = 1'b1;
         default: o_dec.inc = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: fetches the word at pc over req/ack, then issues one
// single-cycle pc command per instruction and forwards the word to the datapath.
//
//   state | meaning
//   IDLE  | first cycle after reset, fetch starts next edge
//   FETCH | imem_req high at pc, waiting for ack (bounded by TIMEOUT)
//   EXEC  | decode instr, pulse one command unless stalled
//   HALT  | halt opcode executed, idle until reset
//   ERROR | fetch timed out, idle until reset
module fetch_seq
   import fetch_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = 8
)(
   input  logic        clk,
   input  logic        reset,
   fetch_seq_if.master bus
);

   localparam int unsigned     CNT_W    = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [INSTR_W-1:0] r_instr;
   dec_t               w_dec;

   fetch_decode u_decode (
      .i_opcode (r_instr[15:12]),
      .i_imm    (r_instr[11:0]),
      .i_zero   (bus.zero),
      .o_dec    (w_dec)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_instr <= '0;
      end else begin
         if (r_state == ST_FETCH && !bus.imem_ack) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
         if (r_state == ST_FETCH && bus.imem_ack) begin
            r_instr <= bus.imem_data;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: w_state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (bus.imem_ack) begin
               w_state_nxt = ST_EXEC;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_ERROR;
            end
         end
         ST_EXEC: begin
            if (!bus.stall) begin
               w_state_nxt = w_dec.is_halt ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT:  w_state_nxt = ST_HALT;
         ST_ERROR: w_state_nxt = ST_ERROR;
         default:  w_state_nxt = ST_ERROR;
      endcase
   end

   // No command is issued while in FETCH, so pc (and thus imem_addr) is
   // stable from FETCH entry until the ack edge.
   always_comb begin
      bus.imem_req    = 1'b0;
      bus.imem_addr   = '0;
      bus.inc         = 1'b0;
      bus.add         = 1'b0;
      bus.sub         = 1'b0;
      bus.offset      = '0;
      bus.instr_valid = 1'b0;
      bus.halted      = 1'b0;
      bus.err         = 1'b0;
      case (r_state)
         ST_FETCH: begin
            bus.imem_req  = 1'b1;
            bus.imem_addr = bus.pc;
         end
         ST_EXEC: begin
            if (!bus.stall) begin
               bus.inc         = w_dec.inc;
               bus.add         = w_dec.add;
               bus.sub         = w_dec.sub;
               bus.offset      = w_dec.offset;
               bus.instr_valid = 1'b1;
            end
         end
         ST_HALT:  bus.halted = 1'b1;
         ST_ERROR: bus.err    = 1'b1;
         default: ;
      endcase
   end

   assign bus.instr = r_instr;

   a_cmd_onehot: assert property (@(posedge clk) disable iff (!reset)
      $onehot0({bus.inc, bus.add, bus.sub}));

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: directed vector table, halt/timeout/reset sequences,
// and randomized instructions checked against a pc-arithmetic reference.
module tb_fetch_seq;
   import fetch_seq_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_seq_if u_if ();

   fetch_seq #(.TIMEOUT(8)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   // pc block model: applies the sequencer's commands on the clock edge
   logic [15:0] tb_pc;
   logic        pc_set_req;
   logic [15:0] pc_set_val;
   always @(posedge clk) begin
      if (pc_set_req)       tb_pc <= pc_set_val;
      else if (u_if.inc)    tb_pc <= tb_pc + 16'd1;
      else if (u_if.add)    tb_pc <= tb_pc + u_if.offset;
      else if (u_if.sub)    tb_pc <= tb_pc - u_if.offset;
   end
   assign u_if.pc = tb_pc;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] m_pc;

   typedef struct {
      logic [15:0] d;
      logic        z;
      int          lat;
      int          ns;
      bit          stray;
      logic [2:0]  cmd;
      logic [15:0] off;
      logic [15:0] npc;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Expected behaviour from the instruction rules, as pc arithmetic.
   function automatic void ref_model(input logic [15:0] d, input logic z, input logic [15:0] pc,
                                     output logic [2:0] cmd, output logic [15:0] off,
                                     output logic [15:0] npc);
      int unsigned op;
      int unsigned imm;
      op  = d[15:12];
      imm = d[11:0];
      if (op == 12) begin
         cmd = 3'b000; off = 16'd0; npc = pc;
      end else if (op == 14 || (op == 13 && z)) begin
         cmd = 3'b010; off = 16'(imm); npc = 16'(pc + imm);
      end else if (op == 15) begin
         cmd = 3'b001; off = 16'(imm); npc = 16'(pc - imm);
      end else begin
         cmd = 3'b100; off = 16'd0; npc = 16'(pc + 1);
      end
   endfunction

   task automatic do_reset(input logic [15:0] start_pc);
      @(negedge clk);
      reset = 1'b0;
      u_if.imem_ack = 1'b0; u_if.stall = 1'b0; u_if.zero = 1'b0;
      pc_set_req = 1'b1; pc_set_val = start_pc;
      #1;
      check("rst_req_addr", 32'({u_if.imem_req, u_if.imem_addr}), 32'd0);
      check("rst_flags", 32'({u_if.inc, u_if.add, u_if.sub, u_if.instr_valid, u_if.halted, u_if.err}), 32'd0);
      check("rst_offset", 32'(u_if.offset), 32'd0);
      check("rst_instr", 32'(u_if.instr), 32'd0);
      repeat (2) @(negedge clk);
      pc_set_req = 1'b0;
      reset = 1'b1;
      m_pc = start_pc;
   endtask

   task automatic run_instr(input logic [15:0] d, input logic z, input int lat, input int ns,
                            input bit stray, input logic [2:0] e_cmd, input logic [15:0] e_off,
                            input logic [15:0] e_npc);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk); #1;
         if (u_if.imem_req === 1'b1) got = 1'b1;
      end
      check("fetch_seen", 32'(got), 32'd1);
      if (!got) return;
      check("imem_addr", 32'(u_if.imem_addr), 32'(m_pc));
      for (int i = 0; i < lat; i++) begin
         @(negedge clk); #1;
         check("req_held", 32'({u_if.imem_req, u_if.imem_addr}), 32'({1'b1, m_pc}));
      end
      u_if.imem_ack = 1'b1; u_if.imem_data = d; u_if.zero = z; u_if.stall = (ns > 0);
      @(negedge clk);
      u_if.imem_ack = stray; u_if.imem_data = ~d;
      for (int s = 0; s < ns; s++) begin
         #1;
         check("stall_hold", 32'({u_if.inc, u_if.add, u_if.sub, u_if.instr_valid, u_if.imem_req}), 32'd0);
         @(negedge clk);
      end
      u_if.stall = 1'b0; u_if.imem_ack = 1'b0;
      #1;
      check("instr", 32'(u_if.instr), 32'(d));
      check("instr_valid", 32'(u_if.instr_valid), 32'd1);
      check("cmd", 32'({u_if.inc, u_if.add, u_if.sub}), 32'(e_cmd));
      check("offset", 32'(u_if.offset), 32'(e_off));
      m_pc = e_npc;
      @(negedge clk); #1;
      check("single_pulse", 32'({u_if.inc, u_if.add, u_if.sub, u_if.instr_valid}), 32'd0);
      if (e_cmd != 3'b000)
         check("next_fetch", 32'({u_if.imem_req, u_if.imem_addr}), 32'({1'b1, e_npc}));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  r_cmd;
      logic [15:0] r_off, r_npc, r_d;
      logic        r_z;
      int unsigned op;
      int          nreq;
      bit          done;

      reset = 1'b0;
      pc_set_req = 1'b1; pc_set_val = 16'h0000;
      u_if.imem_ack = 1'b0; u_if.imem_data = 16'h0000;
      u_if.zero = 1'b0; u_if.stall = 1'b0;

      vecs[0] = '{16'h1234, 1'b0, 1, 0, 1'b0, 3'b100, 16'h0000, 16'h0011};
      vecs[1] = '{16'hE005, 1'b0, 0, 0, 1'b0, 3'b010, 16'h0005, 16'h0016};
      vecs[2] = '{16'hF003, 1'b0, 0, 0, 1'b0, 3'b001, 16'h0003, 16'h0013};
      vecs[3] = '{16'hD020, 1'b1, 0, 3, 1'b1, 3'b010, 16'h0020, 16'h0033};
      vecs[4] = '{16'hD020, 1'b0, 0, 0, 1'b0, 3'b100, 16'h0000, 16'h0034};
      vecs[5] = '{16'hE000, 1'b0, 2, 0, 1'b0, 3'b010, 16'h0000, 16'h0034};
      vecs[6] = '{16'hF000, 1'b0, 0, 1, 1'b1, 3'b001, 16'h0000, 16'h0034};
      vecs[7] = '{16'h7FFF, 1'b1, 0, 0, 1'b0, 3'b100, 16'h0000, 16'h0035};

      do_reset(16'h0010);
      for (int v = 0; v < 8; v++)
         run_instr(vecs[v].d, vecs[v].z, vecs[v].lat, vecs[v].ns, vecs[v].stray,
                   vecs[v].cmd, vecs[v].off, vecs[v].npc);

      // halt: no command, then quiet until reset
      run_instr(16'hC000, 1'b0, 0, 0, 1'b0, 3'b000, 16'h0000, m_pc);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         check("halt_quiet", 32'({u_if.imem_req, u_if.halted, u_if.inc | u_if.add | u_if.sub}), 32'b010);
      end
      do_reset(16'h0100);
      run_instr(16'h2222, 1'b0, 0, 0, 1'b0, 3'b100, 16'h0000, 16'h0101);

      // fetch timeout with ack never arriving
      do_reset(16'h0200);
      nreq = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk); #1;
         if (u_if.err === 1'b1) done = 1'b1;
         else if (u_if.imem_req === 1'b1) begin
            nreq++;
            check("timeout_addr", 32'(u_if.imem_addr), 32'h0200);
         end
      end
      check("timeout_err", 32'(done), 32'd1);
      check("timeout_cycles", 32'(nreq), 32'd8);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         check("err_quiet", 32'({u_if.imem_req, u_if.err, u_if.instr_valid}), 32'b010);
      end

      // reset while a fetch is pending: req drops at once, ack discarded
      do_reset(16'h0300);
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         @(negedge clk); #1;
         if (u_if.imem_req === 1'b1) done = 1'b1;
      end
      check("midfetch_req", 32'(done), 32'd1);
      u_if.imem_ack = 1'b1; u_if.imem_data = 16'hE0FF;
      #1 reset = 1'b0;
      #1;
      check("async_req_drop", 32'({u_if.imem_req, u_if.imem_addr}), 32'd0);
      @(negedge clk);
      u_if.imem_ack = 1'b0;
      reset = 1'b1;
      #1;
      check("ack_discarded", 32'(u_if.instr), 32'd0);
      run_instr(16'h0ABC, 1'b0, 0, 0, 1'b0, 3'b100, 16'h0000, 16'h0301);

      // randomized instruction stream
      do_reset(16'($urandom));
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 14);
         if (op >= 12) op = op + 1;
         r_d = {4'(op), 12'($urandom)};
         r_z = 1'($urandom);
         ref_model(r_d, r_z, m_pc, r_cmd, r_off, r_npc);
         run_instr(r_d, r_z, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   1'($urandom), r_cmd, r_off, r_npc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
